// File: rtl/imm_gen_pkg.sv
// Shared constants for the pipelined immediate generator: format bit indices and opcodes.
package imm_gen_pkg;

  localparam int FMT_W = 6;

  // One-hot format positions in imm_sel / fmt, {Z,U,J,B,S,I} = [5:0]
  localparam int FMT_I = 0;
  localparam int FMT_S = 1;
  localparam int FMT_B = 2;
  localparam int FMT_J = 3;
  localparam int FMT_U = 4;
  localparam int FMT_Z = 5;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Upstream/downstream handshake bundle of imm_gen_pipe; slave is the block's view.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_inst;
  logic [5:0]      i_imm_sel;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_imm;
  logic [5:0]      o_fmt;
  logic            o_sel_err;

  modport slave (
    input  i_valid, i_inst, i_imm_sel, i_flush, i_ready,
    output o_ready, o_valid, o_imm, o_fmt, o_sel_err
  );

  modport master (
    output i_valid, i_inst, i_imm_sel, i_flush, i_ready,
    input  o_ready, o_valid, o_imm, o_fmt, o_sel_err
  );
endinterface

// File: rtl/imm_gen_pipe_extract.sv
// imm_extract: combinational format priority, immediate extraction and extension.
// Opcode auto-decode when sel is zero is enabled by IMM_GEN_PIPE_AUTO_DECODE_EN.
module imm_extract
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]      inst,
  input  logic [FMT_W-1:0] sel,
  output logic [XLEN-1:0]  imm,
  output logic [FMT_W-1:0] fmt,
  output logic             sel_err
);

  logic [FMT_W-1:0] sel_eff;
  logic [31:0]      imm32;

`ifdef IMM_GEN_PIPE_AUTO_DECODE_EN
  logic [FMT_W-1:0] dec;

  always_comb begin
    dec = '0;
    case (inst[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: dec[FMT_I] = 1'b1;
      OPC_STORE:                      dec[FMT_S] = 1'b1;
      OPC_BRANCH:                     dec[FMT_B] = 1'b1;
      OPC_JAL:                        dec[FMT_J] = 1'b1;
      OPC_LUI, OPC_AUIPC:             dec[FMT_U] = 1'b1;
      OPC_SYSTEM:                     dec[FMT_Z] = inst[14];
      default:                        dec = '0;
    endcase
  end

  assign sel_eff = (sel == '0) ? dec : sel;
`else
  logic unused_opcode;
  assign unused_opcode = ^inst[6:0];
  assign sel_eff       = sel;
`endif

  // Error reflects the raw select, not the decoded one
  assign sel_err = (sel & (sel - 6'd1)) != 6'd0;

  always_comb begin
    fmt = '0;
    if (sel_eff[FMT_Z])      fmt[FMT_Z] = 1'b1;
    else if (sel_eff[FMT_U]) fmt[FMT_U] = 1'b1;
    else if (sel_eff[FMT_J]) fmt[FMT_J] = 1'b1;
    else if (sel_eff[FMT_B]) fmt[FMT_B] = 1'b1;
    else if (sel_eff[FMT_S]) fmt[FMT_S] = 1'b1;
    else if (sel_eff[FMT_I]) fmt[FMT_I] = 1'b1;
  end

  always_comb begin
    imm32 = '0;
    if (fmt[FMT_U])      imm32 = {inst[31:12], 12'b0};
    else if (fmt[FMT_J]) imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    else if (fmt[FMT_B]) imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    else if (fmt[FMT_S]) imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    else if (fmt[FMT_I]) imm32 = {{20{inst[31]}}, inst[31:20]};
  end

  // Z is the only zero-extended format; everything else widens from bit 31
  always_comb begin
    if (fmt[FMT_Z]) imm = XLEN'(inst[19:15]);
    else            imm = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: imm_extract feeding an OUT register plus one SKID entry.
// Optional opcode auto-decode via IMM_GEN_PIPE_AUTO_DECODE_EN. XLEN is 32 or 64.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic            i_clk,
  input logic            i_rst_n,
  imm_gen_pipe_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [FMT_W-1:0] fmt;
    logic             sel_err;
  } entry_t;

  logic [XLEN-1:0]  ext_imm;
  logic [FMT_W-1:0] ext_fmt;
  logic             ext_sel_err;
  entry_t           new_e;
  entry_t           out_q;
  entry_t           skid_q;
  logic             out_v;
  logic             skid_v;
  logic             accept;
  logic             consume;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .inst    (bus.i_inst),
    .sel     (bus.i_imm_sel),
    .imm     (ext_imm),
    .fmt     (ext_fmt),
    .sel_err (ext_sel_err)
  );

  assign new_e = '{imm: ext_imm, fmt: ext_fmt, sel_err: ext_sel_err};

  // Handshake: a transfer happens on an edge where valid && ready are both high.
  // Upstream accept also needs !i_flush; o_ready comes only from the SKID flop.
  assign accept  = bus.i_valid && !skid_v && !bus.i_flush;
  assign consume = out_v && bus.i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (bus.i_flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (accept) begin
      if (!out_v || consume) begin
        out_v <= 1'b1;
        if (skid_v) begin
          out_q  <= skid_q;
          skid_q <= new_e;
        end else begin
          out_q <= new_e;
        end
      end else begin
        skid_q <= new_e;
        skid_v <= 1'b1;
      end
    end else if (consume) begin
      if (skid_v) begin
        out_q  <= skid_q;
        skid_v <= 1'b0;
      end else begin
        out_v <= 1'b0;
      end
    end
  end

  assign bus.o_ready   = !skid_v;
  assign bus.o_valid   = out_v;
  assign bus.o_imm     = out_q.imm;
  assign bus.o_fmt     = out_q.fmt;
  assign bus.o_sel_err = out_q.sel_err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 instance for handshake/format cases, XLEN=64 for widening.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) a_if ();
  imm_gen_pipe_if #(.XLEN(64)) b_if ();

  imm_gen_pipe #(.XLEN(32)) u_dut32 (.i_clk(clk), .i_rst_n(rst_n), .bus(a_if.slave));
  imm_gen_pipe #(.XLEN(64)) u_dut64 (.i_clk(clk), .i_rst_n(rst_n), .bus(b_if.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_if.i_valid   = 1'b0;
    a_if.i_inst    = '0;
    a_if.i_imm_sel = '0;
    a_if.i_flush   = 1'b0;
  endtask

  task automatic idle_all();
    idle_a();
    a_if.i_ready   = 1'b1;
    b_if.i_valid   = 1'b0;
    b_if.i_inst    = '0;
    b_if.i_imm_sel = '0;
    b_if.i_flush   = 1'b0;
    b_if.i_ready   = 1'b1;
  endtask

  task automatic drive_a(input logic [31:0] inst, input logic [5:0] sel);
    a_if.i_valid   = 1'b1;
    a_if.i_inst    = inst;
    a_if.i_imm_sel = sel;
  endtask

  task automatic test_reset();
    idle_all();
    #1;
    checks++; if (a_if.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", a_if.o_valid); end
    checks++; if (a_if.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", a_if.o_ready); end
    checks++; if (a_if.o_imm !== 32'h0) begin errors++; $display("FAIL reset_imm got=%h want=0", a_if.o_imm); end
    checks++; if (a_if.o_fmt !== 6'b0) begin errors++; $display("FAIL reset_fmt got=%b want=0", a_if.o_fmt); end
    checks++; if (a_if.o_sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got=%b want=0", a_if.o_sel_err); end
    checks++; if (b_if.o_valid !== 1'b0 || b_if.o_imm !== 64'h0) begin errors++; $display("FAIL reset64 got v=%b imm=%h want v=0 imm=0", b_if.o_valid, b_if.o_imm); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_i_type();
    drive_a(32'hFFF00093, 6'b000001);
    step();
    checks++; if (a_if.o_valid !== 1'b1) begin errors++; $display("FAIL i_valid got=%b want=1", a_if.o_valid); end
    checks++; if (a_if.o_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL i_imm got=%h want=ffffffff", a_if.o_imm); end
    checks++; if (a_if.o_fmt !== 6'b000001) begin errors++; $display("FAIL i_fmt got=%b want=000001", a_if.o_fmt); end
    checks++; if (a_if.o_sel_err !== 1'b0) begin errors++; $display("FAIL i_sel_err got=%b want=0", a_if.o_sel_err); end
    idle_a();
    step();
    checks++; if (a_if.o_valid !== 1'b0) begin errors++; $display("FAIL i_drain got=%b want=0", a_if.o_valid); end
  endtask

  task automatic test_b_type();
    drive_a(32'hFE000EE3, 6'b000100);
    step();
    checks++; if (a_if.o_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL b_imm got=%h want=fffffffc", a_if.o_imm); end
    checks++; if (a_if.o_fmt !== 6'b000100) begin errors++; $display("FAIL b_fmt got=%b want=000100", a_if.o_fmt); end
    idle_a();
    step();
  endtask

  task automatic test_s_and_z();
    drive_a(32'h00A12423, 6'b000010);
    step();
    checks++; if (a_if.o_imm !== 32'h8 || a_if.o_fmt !== 6'b000010) begin errors++; $display("FAIL s_imm got=%h/%b want=8/000010", a_if.o_imm, a_if.o_fmt); end
    drive_a(32'h800FD073, 6'b100000);
    step();
    checks++; if (a_if.o_imm !== 32'h1F || a_if.o_fmt !== 6'b100000) begin errors++; $display("FAIL z_imm got=%h/%b want=1f/100000", a_if.o_imm, a_if.o_fmt); end
    idle_a();
    step();
  endtask

  task automatic test_multi_hot();
    drive_a(32'h12345037, 6'b010100);
    step();
    checks++; if (a_if.o_imm !== 32'h12345000) begin errors++; $display("FAIL mh_imm got=%h want=12345000", a_if.o_imm); end
    checks++; if (a_if.o_fmt !== 6'b010000) begin errors++; $display("FAIL mh_fmt got=%b want=010000", a_if.o_fmt); end
    checks++; if (a_if.o_sel_err !== 1'b1) begin errors++; $display("FAIL mh_sel_err got=%b want=1", a_if.o_sel_err); end
    idle_a();
    step();
  endtask

  task automatic test_no_select();
    logic [31:0] exp_imm;
    logic [5:0]  exp_fmt;
`ifdef IMM_GEN_PIPE_AUTO_DECODE_EN
    exp_imm = 32'h8;
    exp_fmt = 6'b000010;
`else
    exp_imm = 32'h0;
    exp_fmt = 6'b000000;
`endif
    drive_a(32'h00A12423, 6'b000000);
    step();
    checks++; if (a_if.o_valid !== 1'b1) begin errors++; $display("FAIL nosel_valid got=%b want=1", a_if.o_valid); end
    checks++; if (a_if.o_imm !== exp_imm || a_if.o_fmt !== exp_fmt || a_if.o_sel_err !== 1'b0) begin
      errors++; $display("FAIL nosel got=%h/%b/%b want=%h/%b/0", a_if.o_imm, a_if.o_fmt, a_if.o_sel_err, exp_imm, exp_fmt);
    end
    idle_a();
    step();
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 4; k++) begin
      drive_a((32'(k) << 20) | 32'h93, 6'b000001);
      step();
      checks++; if (a_if.o_valid !== 1'b1 || a_if.o_imm !== 32'(k)) begin errors++; $display("FAIL b2b_%0d got v=%b imm=%h want v=1 imm=%h", k, a_if.o_valid, a_if.o_imm, 32'(k)); end
    end
    idle_a();
    step();
    checks++; if (a_if.o_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b want=0", a_if.o_valid); end
  endtask

  task automatic test_backpressure();
    a_if.i_ready = 1'b0;
    drive_a(32'h00100093, 6'b000001);
    step();
    checks++; if (a_if.o_valid !== 1'b1 || a_if.o_imm !== 32'h1 || a_if.o_ready !== 1'b1) begin errors++; $display("FAIL bp_a got v=%b imm=%h rdy=%b want 1/1/1", a_if.o_valid, a_if.o_imm, a_if.o_ready); end
    drive_a(32'h00200093, 6'b000001);
    step();
    checks++; if (a_if.o_ready !== 1'b0 || a_if.o_imm !== 32'h1) begin errors++; $display("FAIL bp_skid got rdy=%b imm=%h want 0/1", a_if.o_ready, a_if.o_imm); end
    drive_a(32'h00300093, 6'b000001);
    step();
    step();
    checks++; if (a_if.o_ready !== 1'b0 || a_if.o_imm !== 32'h1 || a_if.o_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got rdy=%b imm=%h v=%b want 0/1/1", a_if.o_ready, a_if.o_imm, a_if.o_valid); end
    a_if.i_ready = 1'b1;
    step();
    checks++; if (a_if.o_imm !== 32'h2 || a_if.o_ready !== 1'b1) begin errors++; $display("FAIL bp_second got imm=%h rdy=%b want 2/1", a_if.o_imm, a_if.o_ready); end
    step();
    checks++; if (a_if.o_imm !== 32'h3 || a_if.o_valid !== 1'b1) begin errors++; $display("FAIL bp_third got imm=%h v=%b want 3/1", a_if.o_imm, a_if.o_valid); end
    idle_a();
    step();
    checks++; if (a_if.o_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b want=0", a_if.o_valid); end
  endtask

  task automatic test_flush();
    a_if.i_ready = 1'b0;
    drive_a(32'h00500093, 6'b000001);
    step();
    drive_a(32'h00600093, 6'b000001);
    step();
    drive_a(32'h00700093, 6'b000001);
    a_if.i_flush = 1'b1;
    step();
    checks++; if (a_if.o_valid !== 1'b0 || a_if.o_ready !== 1'b1) begin errors++; $display("FAIL flush got v=%b rdy=%b want 0/1", a_if.o_valid, a_if.o_ready); end
    idle_a();
    a_if.i_ready = 1'b1;
    step();
    step();
    checks++; if (a_if.o_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got v=%b imm=%h want v=0", a_if.o_valid, a_if.o_imm); end
  endtask

  task automatic test_reset_mid();
    a_if.i_ready = 1'b0;
    drive_a(32'h00800093, 6'b000001);
    step();
    drive_a(32'h00900093, 6'b000001);
    step();
    idle_a();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (a_if.o_valid !== 1'b0 || a_if.o_ready !== 1'b1 || a_if.o_imm !== 32'h0) begin errors++; $display("FAIL areset got v=%b rdy=%b imm=%h want 0/1/0", a_if.o_valid, a_if.o_ready, a_if.o_imm); end
    #2 rst_n = 1'b1;
    a_if.i_ready = 1'b1;
    step();
  endtask

  task automatic test_xlen64();
    logic [63:0] exp_imm;
    logic [5:0]  exp_fmt;
    b_if.i_valid   = 1'b1;
    b_if.i_inst    = 32'h80000037;
    b_if.i_imm_sel = 6'b010000;
    step();
    checks++; if (b_if.o_imm !== 64'hFFFFFFFF80000000 || b_if.o_fmt !== 6'b010000) begin errors++; $display("FAIL x64_u got=%h/%b want=ffffffff80000000/010000", b_if.o_imm, b_if.o_fmt); end
    b_if.i_inst    = 32'hFFF00093;
    b_if.i_imm_sel = 6'b000001;
    step();
    checks++; if (b_if.o_imm !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL x64_i got=%h want=ffffffffffffffff", b_if.o_imm); end
`ifdef IMM_GEN_PIPE_AUTO_DECODE_EN
    exp_imm = 64'h8;
    exp_fmt = 6'b001000;
`else
    exp_imm = 64'h0;
    exp_fmt = 6'b000000;
`endif
    b_if.i_inst    = 32'h0080006F;
    b_if.i_imm_sel = 6'b000000;
    step();
    checks++; if (b_if.o_imm !== exp_imm || b_if.o_fmt !== exp_fmt) begin errors++; $display("FAIL x64_jal got=%h/%b want=%h/%b", b_if.o_imm, b_if.o_fmt, exp_imm, exp_fmt); end
    b_if.i_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_i_type();
    test_b_type();
    test_s_and_z();
    test_multi_hot();
    test_no_select();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_xlen64();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
